// File: rtl/ire_discharge_sequencer.sv
// IRE pulse-train discharge sequencer: arms on host parameter lock, then paces DDS bursts by ms timer or ECG R-wave.
// Build option IRE_ECG_SYNC_EN adds the ECG synchroniser and ECG-paced mode; without it every run is timer-paced.
module ire_discharge_sequencer #(
   parameter int TICKS_PER_MS = 50000,
   parameter int CYC_W        = 14,
   parameter int CNT_W        = 10
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             cap_ready,
   input  logic             pedal,
   input  logic             ecg_mode,
   input  logic             ecg_sync,
   input  logic [CYC_W-1:0] train_period_ms,
   input  logic [CNT_W-1:0] train_count,
   input  logic             burst_busy,
   output logic             burst_start,
   output logic [CNT_W-1:0] trains_done,
   output logic [2:0]       state,
   output logic             active,
   output logic             complete,
   output logic             fault
);

   localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_MS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_WAIT  = 3'd2,
      S_FIRE  = 3'd3,
      S_BUSY  = 3'd4,
      S_DONE  = 3'd5,
      S_ABORT = 3'd6
   } state_t;

   state_t           st_q;
   logic [PRE_W-1:0] pre_q;
   logic [CYC_W-1:0] ms_q;
   logic             bsy_q;
   logic [CYC_W-1:0] per_q;
   logic [CNT_W-1:0] cnt_q;
   logic             lat_en;
   logic             tmr_exp;
   logic             trig;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign state   = st_q;
   assign lat_en  = arm && (train_count != '0) && ((st_q == S_IDLE) || (st_q == S_ARMED));
   // Expiry is flagged one cycle early so that strobe-to-strobe spacing is exactly P*TICKS_PER_MS.
   assign tmr_exp = (ms_q == '0) || ((ms_q == CYC_W'(1)) && (pre_q == '0));

   // Run parameters are plain data: only ever meaningful after an accepted arm.
   always_ff @(posedge sys_clk) begin
      if (lat_en) begin
         per_q <= train_period_ms;
         cnt_q <= train_count;
      end
   end

`ifdef IRE_ECG_SYNC_EN
   logic ecg_p0;
   logic ecg_p1;
   logic ecg_p2;
   logic ecg_rise_p3;
   logic mode_q;

   always_ff @(posedge sys_clk) begin
      if (lat_en) begin
         mode_q <= ecg_mode;
      end
   end

   // p0/p1: metastability synchroniser; p2: history; p3: registered rising edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ecg_p0      <= 1'b0;
         ecg_p1      <= 1'b0;
         ecg_p2      <= 1'b0;
         ecg_rise_p3 <= 1'b0;
      end else begin
         ecg_p0      <= ecg_sync;
         ecg_p1      <= ecg_p0;
         ecg_p2      <= ecg_p1;
         ecg_rise_p3 <= ecg_p1 & ~ecg_p2;
      end
   end

   assign trig = mode_q ? ecg_rise_p3 : tmr_exp;
`else
   logic unused_ecg;
   assign unused_ecg = ecg_mode ^ ecg_sync;
   assign trig       = tmr_exp;
`endif

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= S_IDLE;
         burst_start <= 1'b0;
         trains_done <= '0;
         active      <= 1'b0;
         complete    <= 1'b0;
         fault       <= 1'b0;
         pre_q       <= '0;
         ms_q        <= '0;
         bsy_q       <= 1'b0;
      end else begin
         burst_start <= 1'b0;
         complete    <= 1'b0;

         // Free-running period countdown; parks at zero once expired.
         if (ms_q != '0) begin
            if (pre_q == '0) begin
               pre_q <= PRE_MAX;
               ms_q  <= ms_q - 1'b1;
            end else begin
               pre_q <= pre_q - 1'b1;
            end
         end

         case (st_q)
            S_IDLE: begin
               active <= 1'b0;
               if (lat_en) begin
                  st_q        <= S_ARMED;
                  trains_done <= '0;
                  fault       <= 1'b0;
               end
            end
            S_ARMED: begin
               if (cap_ready && pedal) begin
                  st_q   <= S_WAIT;
                  active <= 1'b1;
                  ms_q   <= '0;
               end
            end
            S_WAIT: begin
               if (!pedal) begin
                  st_q   <= S_ABORT;
                  fault  <= 1'b1;
                  active <= 1'b0;
               end else if (trig && cap_ready) begin
                  st_q        <= S_FIRE;
                  burst_start <= 1'b1;
                  trains_done <= sat_inc(trains_done);
                  pre_q       <= PRE_MAX;
                  ms_q        <= per_q;
               end
            end
            S_FIRE: begin
               if (!pedal) begin
                  st_q   <= S_ABORT;
                  fault  <= 1'b1;
                  active <= 1'b0;
               end else begin
                  st_q  <= S_BUSY;
                  bsy_q <= 1'b0;
               end
            end
            S_BUSY: begin
               if (!pedal) begin
                  st_q   <= S_ABORT;
                  fault  <= 1'b1;
                  active <= 1'b0;
               end else if (bsy_q && !burst_busy) begin
                  if (trains_done == cnt_q) begin
                     st_q     <= S_DONE;
                     complete <= 1'b1;
                     active   <= 1'b0;
                  end else begin
                     st_q <= S_WAIT;
                  end
               end else begin
                  bsy_q <= 1'b1;
               end
            end
            S_DONE: begin
               st_q <= S_IDLE;
            end
            S_ABORT: begin
               if (!burst_busy) begin
                  st_q <= S_IDLE;
               end
            end
            default: begin
               st_q   <= S_IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ire_discharge_sequencer.sv
// Scoreboard bench for ire_discharge_sequencer, run with a shortened millisecond (TICKS_PER_MS=50).
module tb_ire_discharge_sequencer;

   localparam int TPM   = 50;
   localparam int CYC_W = 14;
   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             arm = 1'b0;
   logic             cap_ready = 1'b0;
   logic             pedal = 1'b0;
   logic             ecg_mode = 1'b0;
   logic             ecg_sync = 1'b0;
   logic [CYC_W-1:0] train_period_ms = '0;
   logic [CNT_W-1:0] train_count = '0;
   logic             burst_busy;
   logic             burst_start;
   logic [CNT_W-1:0] trains_done;
   logic [2:0]       state;
   logic             active;
   logic             complete;
   logic             fault;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dds_len = 20;
   int exp_q[$];

   ire_discharge_sequencer #(.TICKS_PER_MS(TPM), .CYC_W(CYC_W), .CNT_W(CNT_W)) dut (
      .sys_clk(clk), .rst_n(rst_n), .arm(arm), .cap_ready(cap_ready), .pedal(pedal),
      .ecg_mode(ecg_mode), .ecg_sync(ecg_sync), .train_period_ms(train_period_ms),
      .train_count(train_count), .burst_busy(burst_busy), .burst_start(burst_start),
      .trains_done(trains_done), .state(state), .active(active), .complete(complete),
      .fault(fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DDS model: busy for dds_len cycles after each observed start strobe.
   initial begin
      burst_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (burst_start && dds_len > 0) begin
            burst_busy = 1'b1;
            repeat (dds_len) @(negedge clk);
            burst_busy = 1'b0;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0; arm = 1'b0; cap_ready = 1'b0; pedal = 1'b0;
      ecg_mode = 1'b0; ecg_sync = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 200 && burst_busy; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic arm_run(input int p, input int n, input bit mode);
      train_period_ms = CYC_W'(p);
      train_count     = CNT_W'(n);
      ecg_mode        = mode;
      arm             = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic wait_strobe(input int budget, output int at, output bit seen);
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (burst_start) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
   endtask

   task automatic watch(input int n, output int n_strobe, output int n_cmpl);
      n_strobe = 0;
      n_cmpl   = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (burst_start) n_strobe++;
         if (complete) n_cmpl++;
      end
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (burst_start !== 1'b0) begin errors++; $display("FAIL rst_burst_start got %0d want 0", burst_start); end
      checks++; if (trains_done !== '0) begin errors++; $display("FAIL rst_trains_done got %0d want 0", trains_done); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %0d want 0", active); end
      checks++; if (complete !== 1'b0) begin errors++; $display("FAIL rst_complete got %0d want 0", complete); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0d want 0", fault); end
   endtask

   task automatic test_timer_run;
      int at, e, ns, nc;
      bit seen;
      do_reset;
      dds_len = 20;
      arm_run(2, 3, 1'b0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL timer_armed got %0d want 1", state); end
      cap_ready = 1'b1; pedal = 1'b1;
      exp_q.push_back(cyc + 2);
      for (int k = 0; k < 3; k++) begin
         wait_strobe(400, at, seen);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
         checks++; if (!seen || at != e) begin errors++; $display("FAIL timer_strobe%0d got cycle %0d want %0d", k, at, e); end
         if (k == 0) begin
            checks++; if (active !== 1'b1) begin errors++; $display("FAIL timer_active got %0d want 1", active); end
         end
         if (k < 2 && seen) exp_q.push_back(at + 2 * TPM);
      end
      watch(250, ns, nc);
      checks++; if (ns != 0) begin errors++; $display("FAIL timer_extra_strobe got %0d want 0", ns); end
      checks++; if (nc != 1) begin errors++; $display("FAIL timer_complete got %0d want 1", nc); end
      checks++; if (trains_done !== CNT_W'(3)) begin errors++; $display("FAIL timer_trains_done got %0d want 3", trains_done); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL timer_end_state got %0d want 0", state); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timer_fault got %0d want 0", fault); end
   endtask

   task automatic test_pedal_abort;
      int at, e, ns, idle_at;
      bit seen;
      do_reset;
      dds_len = 20;
      arm_run(2, 3, 1'b0);
      cap_ready = 1'b1; pedal = 1'b1;
      exp_q.push_back(cyc + 2);
      for (int k = 0; k < 2; k++) begin
         wait_strobe(400, at, seen);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
         checks++; if (!seen || at != e) begin errors++; $display("FAIL abort_strobe%0d got cycle %0d want %0d", k, at, e); end
         if (k == 0 && seen) exp_q.push_back(at + 2 * TPM);
      end
      repeat (10) @(negedge clk);
      pedal = 1'b0;
      @(negedge clk);
      checks++; if (state !== 3'd6) begin errors++; $display("FAIL abort_state got %0d want 6", state); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL abort_fault got %0d want 1", fault); end
      repeat (4) @(negedge clk);
      checks++; if (state !== 3'd6) begin errors++; $display("FAIL abort_hold got %0d want 6", state); end
      ns = 0;
      idle_at = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (burst_start) ns++;
         if (idle_at < 0 && state == 3'd0) idle_at = cyc;
      end
      checks++; if (ns != 0) begin errors++; $display("FAIL abort_no_strobe got %0d want 0", ns); end
      checks++; if (idle_at < 0) begin errors++; $display("FAIL abort_idle got state %0d want 0", state); end
      checks++; if (trains_done !== CNT_W'(2)) begin errors++; $display("FAIL abort_trains_done got %0d want 2", trains_done); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL abort_fault_sticky got %0d want 1", fault); end
   endtask

   task automatic test_cap_holdoff;
      int at, e, ns, nc;
      bit seen;
      do_reset;
      dds_len = 10;
      arm_run(1, 2, 1'b0);
      cap_ready = 1'b1; pedal = 1'b1;
      exp_q.push_back(cyc + 2);
      wait_strobe(100, at, seen);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (!seen || at != e) begin errors++; $display("FAIL hold_strobe0 got cycle %0d want %0d", at, e); end
      repeat (20) @(negedge clk);
      cap_ready = 1'b0;
      watch(80, ns, nc);
      checks++; if (ns != 0) begin errors++; $display("FAIL hold_no_strobe got %0d want 0", ns); end
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL hold_state got %0d want 2", state); end
      cap_ready = 1'b1;
      exp_q.push_back(cyc + 1);
      wait_strobe(20, at, seen);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (!seen || at != e) begin errors++; $display("FAIL hold_release_strobe got cycle %0d want %0d", at, e); end
      watch(60, ns, nc);
      checks++; if (nc != 1) begin errors++; $display("FAIL hold_complete got %0d want 1", nc); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL hold_fault got %0d want 0", fault); end
   endtask

   task automatic test_arm_checks;
      int at, e, ns, nc;
      bit seen;
      do_reset;
      arm_run(1, 0, 1'b0);
      @(negedge clk);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL arm_zero_count got %0d want 0", state); end
      dds_len = 20;
      arm_run(0, 2, 1'b0);
      cap_ready = 1'b1; pedal = 1'b1;
      exp_q.push_back(cyc + 2);
      wait_strobe(20, at, seen);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (!seen || at != e) begin errors++; $display("FAIL arm_strobe0 got cycle %0d want %0d", at, e); end
      repeat (3) @(negedge clk);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL arm_busy_state got %0d want 4", state); end
      exp_q.push_back(at + 22);
      arm_run(0, 1, 1'b0);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL arm_in_busy_state got %0d want 4", state); end
      wait_strobe(60, at, seen);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++; if (!seen || at != e) begin errors++; $display("FAIL arm_strobe1 got cycle %0d want %0d", at, e); end
      watch(60, ns, nc);
      checks++; if (nc != 1) begin errors++; $display("FAIL arm_complete got %0d want 1", nc); end
      checks++; if (trains_done !== CNT_W'(2)) begin errors++; $display("FAIL arm_trains_done got %0d want 2", trains_done); end
   endtask

   task automatic test_reset_mid_busy;
      int at;
      bit seen;
      do_reset;
      dds_len = 20;
      arm_run(2, 3, 1'b0);
      cap_ready = 1'b1; pedal = 1'b1;
      wait_strobe(20, at, seen);
      repeat (3) @(negedge clk);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL midrst_pre_state got %0d want 4", state); end
      rst_n = 1'b0;
      #1;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL midrst_state got %0d want 0", state); end
      checks++; if (trains_done !== '0) begin errors++; $display("FAIL midrst_trains_done got %0d want 0", trains_done); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL midrst_active got %0d want 0", active); end
      checks++; if (fault !== 1'b0 || complete !== 1'b0 || burst_start !== 1'b0) begin
         errors++; $display("FAIL midrst_flags got %0d%0d%0d want 000", fault, complete, burst_start);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef IRE_ECG_SYNC_EN
   task automatic test_ecg_run;
      int c0, rel, e, n_cmpl;
      do_reset;
      dds_len = 40;
      arm_run(0, 2, 1'b1);
      cap_ready = 1'b1; pedal = 1'b1;
      c0 = cyc;
      n_cmpl = 0;
      for (int i = 0; i < 700; i++) begin
         rel = cyc - c0;
         ecg_sync = ((rel >= 100 && rel < 110) || (rel >= 120 && rel < 130) || (rel >= 500 && rel < 510));
         if (rel == 100 || rel == 500) exp_q.push_back(cyc + 4);
         @(negedge clk);
         if (complete) n_cmpl++;
         if (burst_start) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            checks++;
            if (e < 0 || cyc < e - 1 || cyc > e + 1) begin
               errors++; $display("FAIL ecg_strobe got cycle %0d want %0d+-1", cyc, e);
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ecg_missing got %0d want 0", exp_q.size()); end
      checks++; if (trains_done !== CNT_W'(2)) begin errors++; $display("FAIL ecg_trains_done got %0d want 2", trains_done); end
      checks++; if (n_cmpl != 1) begin errors++; $display("FAIL ecg_complete got %0d want 1", n_cmpl); end
   endtask
`endif

   initial begin
      test_reset;
      test_timer_run;
      test_pedal_abort;
      test_cap_holdoff;
      test_arm_checks;
`ifdef IRE_ECG_SYNC_EN
      test_ecg_run;
`endif
      test_reset_mid_busy;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ire_discharge_sequencer.md
# ire_discharge_sequencer

Sequences IRE pulse-train discharge: after the host locks parameters, it waits for capacitor-charged and pedal-down. It then issues one `burst_start` per pulse train to both DDS channels, paced by an internal ms period timer or by ECG R-wave edges. It counts completed trains and aborts safely on pedal release. It sits between the UART parameter decoder, the debounced pedal/capacitor inputs, and the DDS enable, replacing ad-hoc enable glue.

## Interface
- `TICKS_PER_MS`, 50000: sys_clk cycles per millisecond (50 MHz).
- `CYC_W`, 14: width of train period in ms.
- `CNT_W`, 10: width of train count.
- `sys_clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `arm` in 1: one-cycle parameter-lock strobe from the UART decoder.
- `cap_ready` in 1: debounced capacitor-charged level.
- `pedal` in 1: debounced pedal-pressed level, 1 = pressed.
- `ecg_mode` in 1: 1 = ECG-synchronised, 0 = timer-paced. Sampled at `arm`.
- `ecg_sync` in 1: raw asynchronous ECG trigger.
- `train_period_ms` in CYC_W: train period. Sampled at `arm`.
- `train_count` in CNT_W: trains per run. Sampled at `arm`.
- `burst_busy` in 1: DDS emitting a train.
- `burst_start` out 1: one-cycle DDS enable strobe.
- `trains_done` out CNT_W: trains issued this run.
- `state` out 3: current FSM state.
- `active` out 1: high in WAIT_TRIG, FIRE, BUSY.
- `complete` out 1: one-cycle pulse when the run finishes normally.
- `fault` out 1: sticky abort flag; cleared by the next accepted `arm`.

## Operation
- State encodings:
  - IDLE=0, ARMED=1, WAIT_TRIG=2, FIRE=3, BUSY=4, DONE=5, ABORT=6.
  - Values 7 recover to IDLE.
- IDLE:
  - `arm` with `train_count`≠0 → ARMED. Latches period, count and mode; clears `trains_done` and `fault`.
  - `arm` with count 0 is ignored.
- ARMED:
  - `arm` re-latches parameters and stays in ARMED.
  - `cap_ready & pedal` → WAIT_TRIG; period timer forced expired.
- WAIT_TRIG, trigger rules:
  - Timer mode: trigger when the timer is expired.
  - ECG mode: trigger on a synchronised rising edge of `ecg_sync`.
  - In either mode, triggers fire only while `cap_ready`=1 → FIRE.
  - `cap_ready` low holds off without aborting. An expired timer fires as soon as `cap_ready` returns. An ECG edge seen while `cap_ready`=0 is discarded.
- FIRE:
  - `burst_start`=1 for exactly one cycle.
  - `trains_done`+1; timer reloads to `train_period_ms`·TICKS_PER_MS cycles; → BUSY.
- BUSY:
  - Exit after at least 2 cycles in state and `burst_busy`=0.
  - If `trains_done`==latched count → DONE, else → WAIT_TRIG.
  - ECG edges arriving in BUSY are dropped, not queued.
- DONE: `complete`=1 for one cycle → IDLE.
- Pedal release:
  - Abort applies when `pedal`=0 in WAIT_TRIG, FIRE or BUSY.
  - Effect: → ABORT, `fault`=1; no further `burst_start`, including in the same cycle.
  - The train already in flight is not cut.
- ABORT: leave to IDLE when `burst_busy`=0.
- `arm` is ignored in WAIT_TRIG, FIRE, BUSY, DONE and ABORT.
- Period timer:
  - Implemented as a ms prescaler (0..TICKS_PER_MS-1) plus a CYC_W ms down-counter; no multiplier.
  - Measured from `burst_start` to `burst_start`.
  - `train_period_ms`=0 means back-to-back trains, gated only by BUSY.
- `trains_done` saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset values: `burst_start`=0, `trains_done`=0, `state`=IDLE, `active`=0, `complete`=0, `fault`=0. Timer is cleared and ECG synchronisers are zeroed.
- All outputs are registered.
- Timer mode: first `burst_start` is high on the 2nd edge after the edge that samples `cap_ready & pedal`=1 in ARMED.
- Subsequent trains: `burst_start` rising edges are exactly max(P·TICKS_PER_MS, BUSY exit + 1) cycles apart.
- ECG mode: `ecg_sync` passes a 2-flop synchroniser plus an edge register. `burst_start` is high 4 edges after the first edge sampling `ecg_sync`=1, ±1 cycle for metastability.
- Pedal abort: `state`=ABORT and `fault`=1 on the edge after `pedal` is sampled low.
- Reset mid-run drops to IDLE immediately. Downstream DDS state is not this block's concern.

## Configuration
- `IRE_ECG_SYNC_EN` defined:
  - ECG path, synchroniser and edge detector are built.
  - `ecg_mode` selects pacing as described.
- Not defined:
  - `ecg_mode` and `ecg_sync` are ignored; the ECG logic is not synthesised.
  - All runs are timer-paced.

## Test plan
- Timer run, sustained inputs:
  - Stimulus: `arm` with P=2 ms, N=3; `cap_ready`=`pedal`=1; `burst_busy` high 500 cycles after each start.
  - Response: three `burst_start` strobes exactly 100000 cycles apart; `trains_done`=3; one `complete` pulse; state returns to 0.
- Pedal abort:
  - Stimulus: same run as above, with `pedal` dropped 10 cycles after the 2nd `burst_start`.
  - Response: `fault`=1 next cycle; no 3rd strobe; IDLE after `burst_busy` falls; `trains_done`=2.
- ECG run (macro defined):
  - Stimulus: `ecg_mode`=1, N=2; ECG edges at 1000, 1200 (inside BUSY, `burst_busy` held 400 cycles) and 5000 cycles.
  - Response: strobes only for the 1000 and 5000 edges, each 4±1 cycles after its edge.
- Capacitor hold-off:
  - Stimulus: timer mode P=1 ms; `cap_ready` low for 80000 cycles spanning an expiry.
  - Response: no strobe while low; strobe 1 cycle after it returns; `fault`=0.
- Argument and state checks:
  - `arm` with N=0 leaves state IDLE.
  - `arm` during BUSY leaves the latched count unchanged.
  - Reset mid-BUSY: all outputs at reset values.
